// File: rtl/imul_mac_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | imul_mac_stage: pipelined unsigned multiply-accumulate over framed  |
// | term streams, one result per stream on a valid/ready handshake.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+

module imul_radix4_mult #(
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] p
);
  localparam int PW = 2 * SIZE;
  localparam int NPP = SIZE / 2;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] a2;
  logic [PW-1:0] a3;
  logic [PW-1:0] pp [NPP];
  logic [PW-1:0] sum;

  assign a_ext = {{SIZE{1'b0}}, a};
  assign a2    = a_ext << 1;
  assign a3    = a_ext + a2;

  // One partial product per 2-bit digit of b, selected from {0, A, 2A, 3A}.
  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [1:0] digit;
    assign digit = b[2*i+1:2*i];
    assign pp[i] = ((digit == 2'd0) ? '0 :
                    (digit == 2'd1) ? a_ext :
                    (digit == 2'd2) ? a2 : a3) << (2 * i);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NPP; i++) begin
      sum = sum + pp[i];
    end
  end

  assign p = sum;
endmodule

module imul_mac_stage #(
  parameter int SIZE     = 16,
  parameter int ACC_SIZE = 40
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                iValid,
  output logic                oReady,
  input  logic [SIZE-1:0]     A,
  input  logic [SIZE-1:0]     B,
  input  logic                iClear,
  input  logic                iLast,
  output logic                oValid,
  input  logic                iReady,
  output logic [ACC_SIZE-1:0] oResult,
  output logic                oOverflow,
  output logic [15:0]         oTerms
);
  localparam int PW = 2 * SIZE;

  logic                en;
  logic [PW-1:0]       prod;

  logic                v1_q, v1_d, clr1_q, clr1_d, last1_q, last1_d;
  logic [SIZE-1:0]     a1_q, a1_d, b1_q, b1_d;
  logic                v2_q, v2_d, clr2_q, clr2_d, last2_q, last2_d;
  logic [PW-1:0]       p2_q, p2_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ACC_SIZE-1:0] result_q, result_d;
  logic                ovf_out_q, ovf_out_d;
  logic [15:0]         terms_q, terms_d;
  logic                out_valid_q, out_valid_d;

  logic [ACC_SIZE-1:0] acc_base;
  logic [ACC_SIZE:0]   sum_ext;
  logic                ovf_new;
  logic [15:0]         cnt_base;
  logic [15:0]         cnt_new;

  imul_radix4_mult #(.SIZE(SIZE)) u_mult (
    .a (a1_q),
    .b (b1_q),
    .p (prod)
  );

  // A Clear term treats all running stream state as zero before adding itself.
  always_comb begin
    acc_base = clr2_q ? '0 : acc_q;
    sum_ext  = {1'b0, acc_base} + {{(ACC_SIZE + 1 - PW){1'b0}}, p2_q};
    ovf_new  = (clr2_q ? 1'b0 : ovf_acc_q) | sum_ext[ACC_SIZE];
    cnt_base = clr2_q ? 16'd0 : cnt_q;
    cnt_new  = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
  end

  always_comb begin
    en          = !out_valid_q || iReady;
    v1_d        = v1_q;
    a1_d        = a1_q;
    b1_d        = b1_q;
    clr1_d      = clr1_q;
    last1_d     = last1_q;
    v2_d        = v2_q;
    p2_d        = p2_q;
    clr2_d      = clr2_q;
    last2_d     = last2_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    ovf_out_d   = ovf_out_q;
    terms_d     = terms_q;
    out_valid_d = out_valid_q;
    if (en) begin
      v1_d        = iValid;
      a1_d        = A;
      b1_d        = B;
      clr1_d      = iClear;
      last1_d     = iLast;
      v2_d        = v1_q;
      p2_d        = prod;
      clr2_d      = clr1_q;
      last2_d     = last1_q;
      out_valid_d = v2_q && last2_q;
      if (v2_q) begin
        if (last2_q) begin
          result_d  = sum_ext[ACC_SIZE-1:0];
          ovf_out_d = ovf_new;
          terms_d   = cnt_new;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = 16'd0;
        end else begin
          acc_d     = sum_ext[ACC_SIZE-1:0];
          ovf_acc_d = ovf_new;
          cnt_d     = cnt_new;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      v1_q        <= 1'b0;
      a1_q        <= '0;
      b1_q        <= '0;
      clr1_q      <= 1'b0;
      last1_q     <= 1'b0;
      v2_q        <= 1'b0;
      p2_q        <= '0;
      clr2_q      <= 1'b0;
      last2_q     <= 1'b0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      cnt_q       <= 16'd0;
      result_q    <= '0;
      ovf_out_q   <= 1'b0;
      terms_q     <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      clr1_q      <= clr1_d;
      last1_q     <= last1_d;
      v2_q        <= v2_d;
      p2_q        <= p2_d;
      clr2_q      <= clr2_d;
      last2_q     <= last2_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      ovf_out_q   <= ovf_out_d;
      terms_q     <= terms_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign oReady    = en;
  assign oValid    = out_valid_q;
  assign oResult   = result_q;
  assign oOverflow = ovf_out_q;
  assign oTerms    = terms_q;
endmodule
`default_nettype wire

// File: tb/tb_imul_mac_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_imul_mac_stage: self-checking bench for imul_mac_stage.         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_imul_mac_stage;
  logic        Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset, iValid, iClear, iLast, iReady;
  logic [15:0] A, B;
  logic        oReady, oValid, oOverflow;
  logic [39:0] oResult;
  logic [15:0] oTerms;

  logic        s_valid, s_clear, s_last, s_iready;
  logic [3:0]  s_a, s_b;
  logic        s_oready, s_ovalid, s_ovf;
  logic [7:0]  s_res;
  logic [15:0] s_terms;

  imul_mac_stage #(.SIZE(16), .ACC_SIZE(40)) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .A(A), .B(B), .iClear(iClear), .iLast(iLast), .oValid(oValid),
    .iReady(iReady), .oResult(oResult), .oOverflow(oOverflow), .oTerms(oTerms)
  );

  imul_mac_stage #(.SIZE(4), .ACC_SIZE(8)) dut_s (
    .Clock(Clock), .Reset(Reset), .iValid(s_valid), .oReady(s_oready),
    .A(s_a), .B(s_b), .iClear(s_clear), .iLast(s_last), .oValid(s_ovalid),
    .iReady(s_iready), .oResult(s_res), .oOverflow(s_ovf), .oTerms(s_terms)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [39:0] res;
    logic        ovf;
    logic [15:0] terms;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    int     a;
    int     b;
    bit     clr;
    bit     last;
    int     idle;
    longint res;
    int     terms;
    bit     ovf;
  } vec_t;
  vec_t tbl[12];

  // Stream-level reference: running sum of products per stream.
  logic [39:0] m_acc = '0;
  logic        m_ovf = 1'b0;
  int          m_cnt = 0;
  bit          rand_bp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic clr,
                      input logic last, input bit has_exp, input logic [39:0] er,
                      input logic eo, input logic [15:0] et);
    bit          ok;
    int          guard;
    logic [40:0] s;
    exp_t        e;
    guard  = 0;
    A      = a;
    B      = b;
    iClear = clr;
    iLast  = last;
    iValid = 1'b1;
    do begin
      @(negedge Clock);
      ok = oReady;
      @(posedge Clock);
      #1;
      guard++;
    end while (!ok && guard < 200);
    iValid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept, expected accept within 200 cycles");
      return;
    end
    if (clr) begin
      m_acc = '0;
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    s     = {1'b0, m_acc} + 41'(a) * 41'(b);
    m_ovf = m_ovf | s[40];
    m_acc = s[39:0];
    m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    if (last) begin
      if (has_exp) begin
        e.res = er; e.ovf = eo; e.terms = et;
      end else begin
        e.res = m_acc; e.ovf = m_ovf; e.terms = 16'(m_cnt);
      end
      exp_q.push_back(e);
      m_acc = '0;
      m_ovf = 1'b0;
      m_cnt = 0;
    end
  endtask

  always @(negedge Clock) begin
    if (Reset === 1'b1 && oValid === 1'b1 && iReady === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d, expected no result", oResult);
      end else begin
        mon_e = exp_q.pop_front();
        check("result",   64'(oResult),   64'(mon_e.res));
        check("overflow", 64'(oOverflow), 64'(mon_e.ovf));
        check("terms",    64'(oTerms),    64'(mon_e.terms));
      end
    end
  end

  always @(posedge Clock) begin
    #1;
    if (rand_bp) iReady = ($urandom_range(0, 9) < 7);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{3, 4, 1'b1, 1'b0, 0, 0, 0, 1'b0};
    tbl[1]  = '{5, 6, 1'b0, 1'b0, 0, 0, 0, 1'b0};
    tbl[2]  = '{7, 8, 1'b0, 1'b1, 0, 98, 3, 1'b0};
    tbl[3]  = '{2, 2, 1'b0, 1'b1, 0, 4, 1, 1'b0};
    tbl[4]  = '{3, 4, 1'b1, 1'b0, 1, 0, 0, 1'b0};
    tbl[5]  = '{5, 6, 1'b0, 1'b0, 2, 0, 0, 1'b0};
    tbl[6]  = '{7, 8, 1'b0, 1'b1, 3, 98, 3, 1'b0};
    tbl[7]  = '{100, 100, 1'b1, 1'b0, 0, 0, 0, 1'b0};
    tbl[8]  = '{9, 9, 1'b1, 1'b0, 0, 0, 0, 1'b0};
    tbl[9]  = '{10, 10, 1'b0, 1'b1, 0, 181, 2, 1'b0};
    tbl[10] = '{65535, 65535, 1'b1, 1'b1, 1, 64'd4294836225, 1, 1'b0};
    tbl[11] = '{1, 1, 1'b0, 1'b1, 0, 1, 1, 1'b0};

    Reset = 1'b0; iValid = 1'b0; iClear = 1'b0; iLast = 1'b0; iReady = 1'b1;
    A = '0; B = '0;
    s_valid = 1'b0; s_clear = 1'b0; s_last = 1'b0; s_iready = 1'b1; s_a = '0; s_b = '0;

    repeat (3) @(posedge Clock);
    #1;
    check("rst_valid",  64'(oValid),    0);
    check("rst_result", 64'(oResult),   0);
    check("rst_terms",  64'(oTerms),    0);
    check("rst_ovf",    64'(oOverflow), 0);
    check("rst_ready",  64'(oReady),    1);
    Reset = 1'b1;
    idle(2);

    // Single-term stream: result visible exactly two edges after acceptance.
    A = 16'd15; B = 16'd15; iClear = 1'b1; iLast = 1'b1; iValid = 1'b1;
    mon_e.res = 40'd225; mon_e.ovf = 1'b0; mon_e.terms = 16'd1;
    exp_q.push_back(mon_e);
    @(posedge Clock); #1; iValid = 1'b0;
    check("lat_e0_valid", 64'(oValid), 0);
    @(posedge Clock); #1;
    check("lat_e1_valid", 64'(oValid), 0);
    @(posedge Clock); #1;
    check("lat_e2_valid",  64'(oValid),  1);
    check("lat_e2_result", 64'(oResult), 225);
    @(posedge Clock); #1;
    check("lat_e3_valid", 64'(oValid), 0);

    for (int i = 0; i < 12; i++) begin
      idle(tbl[i].idle);
      send(16'(tbl[i].a), 16'(tbl[i].b), tbl[i].clr, tbl[i].last, 1'b1,
           40'(tbl[i].res), tbl[i].ovf, 16'(tbl[i].terms));
    end
    idle(4);

    // Back-pressure with a second stream frozen in the pipeline.
    send(16'd1, 16'd2, 1'b1, 1'b1, 1'b1, 40'd2, 1'b0, 16'd1);
    send(16'd3, 16'd3, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    send(16'd4, 16'd4, 1'b0, 1'b1, 1'b1, 40'd25, 1'b0, 16'd2);
    iReady = 1'b0;
    fork
      send(16'd5, 16'd5, 1'b1, 1'b1, 1'b1, 40'd25, 1'b0, 16'd1);
      begin
        repeat (5) begin
          @(negedge Clock);
          check("bp_ready",  64'(oReady),  0);
          check("bp_valid",  64'(oValid),  1);
          check("bp_hold",   64'(oResult), 2);
        end
        @(posedge Clock); #1;
        iReady = 1'b1;
      end
    join
    idle(6);
    check("bp_drained", 64'(exp_q.size()), 0);

    // Narrow instance: carry out of the accumulator is sticky for the stream.
    s_a = 4'd15; s_b = 4'd15; s_clear = 1'b1; s_last = 1'b0; s_valid = 1'b1;
    @(posedge Clock); #1;
    s_clear = 1'b0; s_last = 1'b1;
    @(posedge Clock); #1;
    s_a = 4'd1; s_b = 4'd1; s_clear = 1'b1; s_last = 1'b1;
    @(posedge Clock); #1;
    s_valid = 1'b0;
    @(posedge Clock); #1;
    check("ovf_s1_valid",  64'(s_ovalid), 1);
    check("ovf_s1_result", 64'(s_res),    194);
    check("ovf_s1_ovf",    64'(s_ovf),    1);
    check("ovf_s1_terms",  64'(s_terms),  2);
    @(posedge Clock); #1;
    check("ovf_s2_valid",  64'(s_ovalid), 1);
    check("ovf_s2_result", 64'(s_res),    1);
    check("ovf_s2_ovf",    64'(s_ovf),    0);
    check("ovf_s2_terms",  64'(s_terms),  1);
    idle(2);

    // Asynchronous reset while a result is held and a stream is partially in.
    send(16'd9, 16'd9, 1'b1, 1'b1, 1'b1, 40'd81, 1'b0, 16'd1);
    send(16'd1, 16'd1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    send(16'd2, 16'd2, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    iReady = 1'b0;
    #2;
    check("prerst_valid",  64'(oValid),  1);
    check("prerst_result", 64'(oResult), 81);
    Reset = 1'b0;
    #1;
    check("arst_valid",  64'(oValid),    0);
    check("arst_result", 64'(oResult),   0);
    check("arst_terms",  64'(oTerms),    0);
    check("arst_ovf",    64'(oOverflow), 0);
    exp_q.delete();
    m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
    @(negedge Clock);
    iReady = 1'b1;
    Reset  = 1'b1;
    @(posedge Clock); #1;
    send(16'd2, 16'd3, 1'b1, 1'b1, 1'b1, 40'd6, 1'b0, 16'd1);
    idle(5);
    check("arst_drained", 64'(exp_q.size()), 0);

    // Randomized streams with random back-pressure against the reference.
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      send(16'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 4) == 0), 1'b0, '0, 1'b0, '0);
    end
    send(16'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    rand_bp = 1'b0;
    @(posedge Clock); #2;
    iReady = 1'b1;
    idle(10);
    check("final_drained", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
